// File: rtl/sub_serial_n.sv
// Multi-cycle N-bit subtractor: diff = a - b - b_in, K bits per clock, valid/ready on both sides.
// Optional signed-overflow output `ovf` is enabled by defining SUB_SERIAL_OVF_EN.
module sub_serial_n #(
    parameter int N = 32,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         b_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] diff,
    output logic         b_out,
    output logic         out_valid,
    input  logic         out_ready
`ifdef SUB_SERIAL_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CHUNKS = N / K;
    localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [N-1:0]     a_r;
    logic [N-1:0]     b_r;
    logic [N-1:0]     diff_r;
    logic [N-1:0]     diff_s;
    logic             borrow_r;
    logic             b_out_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [K:0]       chunk_s;
    logic             accept_s;
    logic             last_s;

    // One K-bit slice: returns {borrow_out, difference} from a + ~b + ~borrow_in.
    function automatic logic [K:0] sub_chunk(input logic [K-1:0] x, input logic [K-1:0] y,
                                             input logic bin);
        logic [K:0] sum;
        sum = {1'b0, x} + {1'b0, ~y} + {{K{1'b0}}, ~bin};
        return {~sum[K], sum[K-1:0]};
    endfunction

    // Handshake decode and the current chunk result.
    always_comb begin
        accept_s = (state_r == ST_IDLE) && in_valid;
        last_s   = (cnt_r == CNT_W'(CHUNKS - 1));
        chunk_s  = sub_chunk(a_r[K-1:0], b_r[K-1:0], borrow_r);
    end

    // The chunk result enters the difference register from the top.
    if (K == N) begin : g_single
        assign diff_s = chunk_s[K-1:0];
    end else begin : g_multi
        assign diff_s = {chunk_s[K-1:0], diff_r[N-1:K]};
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_BUSY;
                else          state_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (last_s) state_s = ST_DONE;
                else        state_s = ST_BUSY;
            end
            ST_DONE: begin
                if (out_ready) state_s = ST_IDLE;
                else           state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register with handshake outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == ST_IDLE);
            out_valid_r <= (state_s == ST_DONE);
        end
    end

    // Operand shift registers, borrow chain, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= {N{1'b0}};
            b_r      <= {N{1'b0}};
            diff_r   <= {N{1'b0}};
            borrow_r <= 1'b0;
            b_out_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r      <= a;
                        b_r      <= b;
                        borrow_r <= b_in;
                        cnt_r    <= {CNT_W{1'b0}};
                    end
                end
                ST_BUSY: begin
                    a_r      <= a_r >> K;
                    b_r      <= b_r >> K;
                    borrow_r <= chunk_s[K];
                    diff_r   <= diff_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (last_s) b_out_r <= chunk_s[K];
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

`ifdef SUB_SERIAL_OVF_EN
    logic a_msb_r;
    logic b_msb_r;
    logic ovf_r;

    // Sign bits are kept aside because the operand registers shift away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                a_msb_r <= a[N-1];
                b_msb_r <= b[N-1];
            end
            if ((state_r == ST_BUSY) && last_s) begin
                ovf_r <= (a_msb_r ^ b_msb_r) & (chunk_s[K-1] ^ a_msb_r);
            end
        end
    end

    assign ovf = ovf_r;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign diff      = diff_r;
    assign b_out     = b_out_r;

endmodule

// File: tb/tb_sub_serial_n.sv
// Bench for sub_serial_n: directed cases on a K=4 instance plus random back-to-back
// streams on K=1/4/8/32 instances, all checked against a plain-arithmetic model.
module tb_sub_serial_n;

    localparam int N = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int streams_done = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // {b_out, diff} of a - b - b_in taken over N+1 bits.
    function automatic logic [N:0] ref_sub(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic bin);
        return {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bin};
    endfunction

    function automatic logic ref_ovf(input logic [N-1:0] x, input logic [N-1:0] y,
                                     input logic [N-1:0] d);
        return (x[N-1] ^ y[N-1]) & (d[N-1] ^ x[N-1]);
    endfunction

    // ---------------- directed instance (K=4) ----------------
    logic         m_rst_n;
    logic [N-1:0] m_a, m_b, m_diff;
    logic         m_bin, m_iv, m_ir, m_bo, m_ov, m_or;
`ifdef SUB_SERIAL_OVF_EN
    logic         m_ovf;
`endif

    sub_serial_n #(.N(N), .K(4)) u_dut (
        .clk(clk), .rst_n(m_rst_n), .a(m_a), .b(m_b), .b_in(m_bin),
        .in_valid(m_iv), .in_ready(m_ir), .diff(m_diff), .b_out(m_bo),
        .out_valid(m_ov), .out_ready(m_or)
`ifdef SUB_SERIAL_OVF_EN
        , .ovf(m_ovf)
`endif
    );

    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic bin,
                          input int hold);
        logic [N:0] e;
        int lat;
        e = ref_sub(x, y, bin);
        @(negedge clk);
        m_a = x; m_b = y; m_bin = bin; m_iv = 1'b1; m_or = (hold == 0);
        check_eq("ready_before_accept", 64'(m_ir), 64'd1);
        @(negedge clk);
        m_iv = 1'b0; m_a = $urandom; m_b = $urandom; m_bin = 1'($urandom_range(0, 1));
        lat = 0;
        while (!m_ov && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 64'(lat), 64'd8);
        check_eq("diff", 64'(m_diff), 64'(e[N-1:0]));
        check_eq("b_out", 64'(m_bo), 64'(e[N]));
`ifdef SUB_SERIAL_OVF_EN
        check_eq("ovf", 64'(m_ovf), 64'(ref_ovf(x, y, e[N-1:0])));
`endif
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                check_eq("hold_diff", 64'(m_diff), 64'(e[N-1:0]));
                check_eq("hold_b_out", 64'(m_bo), 64'(e[N]));
                check_eq("hold_in_ready", 64'(m_ir), 64'd0);
                check_eq("hold_out_valid", 64'(m_ov), 64'd1);
                @(negedge clk);
            end
            m_or = 1'b1;
        end
        @(negedge clk);
        m_or = 1'b0;
        check_eq("ready_after_consume", 64'(m_ir), 64'd1);
        check_eq("valid_after_consume", 64'(m_ov), 64'd0);
    endtask

    initial begin
        m_rst_n = 1'b0; m_a = '0; m_b = '0; m_bin = 1'b0; m_iv = 1'b0; m_or = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", 64'(m_ir), 64'd1);
        check_eq("rst_out_valid", 64'(m_ov), 64'd0);
        check_eq("rst_diff", 64'(m_diff), 64'd0);
        check_eq("rst_b_out", 64'(m_bo), 64'd0);
`ifdef SUB_SERIAL_OVF_EN
        check_eq("rst_ovf", 64'(m_ovf), 64'd0);
`endif
        m_rst_n = 1'b1;

        run_op(32'd5, 32'd3, 1'b0, 0);
        run_op(32'd0, 32'd1, 1'b0, 0);
        run_op(32'd0, 32'd0, 1'b1, 0);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 5);

        // reset during the 4th BUSY cycle
        @(negedge clk);
        m_a = 32'hFFFF_FFFF; m_b = 32'd0; m_bin = 1'b0; m_iv = 1'b1; m_or = 1'b1;
        @(negedge clk);
        m_iv = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("busy_in_ready", 64'(m_ir), 64'd0);
        m_rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(m_ov), 64'd0);
        check_eq("midrst_in_ready", 64'(m_ir), 64'd1);
        check_eq("midrst_diff", 64'(m_diff), 64'd0);
        @(negedge clk);
        m_rst_n = 1'b1; m_or = 1'b0;
        run_op(32'd10, 32'd7, 1'b0, 0);

        run_op(32'h8000_0000, 32'd1, 1'b0, 0);
        run_op(32'd5, 32'd3, 1'b0, 0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);

        for (int w = 0; w < 40000 && streams_done < 4; w++) @(negedge clk);
        check_eq("streams_done", 64'(streams_done), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- random back-to-back streams ----------------
    for (genvar g = 0; g < 4; g++) begin : gen_stream
        localparam int KG = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 32;
        localparam int NOPS = 100;

        logic         rst_g_n, iv, ir, ov, orr, bi, bo;
        logic [N-1:0] ga, gb, gd;
`ifdef SUB_SERIAL_OVF_EN
        logic         go;
`endif

        sub_serial_n #(.N(N), .K(KG)) u_dut (
            .clk(clk), .rst_n(rst_g_n), .a(ga), .b(gb), .b_in(bi),
            .in_valid(iv), .in_ready(ir), .diff(gd), .b_out(bo),
            .out_valid(ov), .out_ready(orr)
`ifdef SUB_SERIAL_OVF_EN
            , .ovf(go)
`endif
        );

        initial begin : stim
            logic [N:0]   exp_q[$];
            logic [N-1:0] ea_q[$];
            logic [N-1:0] eb_q[$];
            int           acc_q[$];
            int           cyc, n_acc, n_res;
            bit           ov_seen;
            rst_g_n = 1'b0; iv = 1'b0; orr = 1'b0; ga = '0; gb = '0; bi = 1'b0;
            cyc = 0; n_acc = 0; n_res = 0; ov_seen = 1'b0;
            repeat (2) @(negedge clk);
            rst_g_n = 1'b1;
            while (n_res < NOPS && cyc < 20000) begin
                @(negedge clk);
                cyc++;
                if (ov && !ov_seen) begin
                    ov_seen = 1'b1;
                    check_eq($sformatf("k%0d_pending", KG), 64'(acc_q.size()), 64'd1);
                    if (acc_q.size() > 0)
                        check_eq($sformatf("k%0d_latency", KG), 64'(cyc - acc_q[0]),
                                 64'(N / KG + 1));
                end
                ga  = $urandom;
                gb  = $urandom;
                bi  = 1'($urandom_range(0, 1));
                orr = ($urandom_range(0, 3) != 0);
                iv  = (n_acc < NOPS);
                if (iv && ir) begin
                    exp_q.push_back(ref_sub(ga, gb, bi));
                    ea_q.push_back(ga);
                    eb_q.push_back(gb);
                    acc_q.push_back(cyc);
                    n_acc++;
                end
                if (ov && orr && exp_q.size() > 0) begin
                    check_eq($sformatf("k%0d_diff", KG), 64'(gd), 64'(exp_q[0][N-1:0]));
                    check_eq($sformatf("k%0d_b_out", KG), 64'(bo), 64'(exp_q[0][N]));
`ifdef SUB_SERIAL_OVF_EN
                    check_eq($sformatf("k%0d_ovf", KG), 64'(go),
                             64'(ref_ovf(ea_q[0], eb_q[0], exp_q[0][N-1:0])));
`endif
                    void'(exp_q.pop_front());
                    void'(ea_q.pop_front());
                    void'(eb_q.pop_front());
                    void'(acc_q.pop_front());
                    n_res++;
                    ov_seen = 1'b0;
                end
            end
            check_eq($sformatf("k%0d_results", KG), 64'(n_res), 64'(NOPS));
            check_eq($sformatf("k%0d_accepts", KG), 64'(n_acc), 64'(NOPS));
            iv = 1'b0;
            streams_done++;
        end
    end

endmodule

// File: doc/sub_serial_n.md
# sub_serial_n

Multi-cycle N-bit subtractor: computes `diff = a - b - b_in` and the final borrow `b_out`, processing K bits per clock with a registered borrow chain. It is the inverse-direction companion to the combinational `adder_n` ripple adder. It is used where a full-width combinational path is too long or too large. Operands enter through a valid/ready handshake, and the result leaves through one.

## Interface
Parameters:
- `N`, 32: operand width; must be a multiple of `K`.
- `K`, 4: bits processed per cycle; latency is `N/K` cycles.

Ports:
- `clk`  in  1  — single clock; everything is on the rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `a`  in  N  — minuend.
- `b`  in  N  — subtrahend.
- `b_in`  in  1  — borrow in.
- `in_valid`  in  1  — operands are valid.
- `in_ready`  out  1  — block can accept operands.
- `diff`  out  N  — difference, registered.
- `b_out`  out  1  — final borrow: 1 when a < b + b_in, unsigned.
- `out_valid`  out  1  — `diff`/`b_out` are valid.
- `out_ready`  in  1  — consumer accepts the result.
- `ovf`  out  1  — signed overflow; present only with `SUB_SERIAL_OVF_EN`.

## Operation
- States:
  - IDLE: `in_ready=1`.
  - BUSY: processing chunks.
  - DONE: `out_valid=1`.
- Transitions:
  - IDLE→BUSY on `in_valid & in_ready`. The edge latches `a`, `b` and `b_in` into internal shift registers and clears the chunk counter.
  - BUSY: one chunk per cycle, LSB chunk first. Chunk i computes `{c, d} = a[i] + ~b[i] + ~borrow`, K+1 bits wide. New borrow = `~c`, and `d` is shifted into the `diff` register from the top.
  - BUSY→DONE after chunk `N/K-1`. The final borrow is latched into `b_out`.
  - DONE→IDLE on `out_valid & out_ready`.
- Arithmetic: modulo 2^N. `b_out` is the unsigned borrow, so `diff + b + b_in = a + b_out·2^N`.
- `diff` and `b_out` hold stable throughout DONE. Their value outside DONE is don't-care, but they must not be X after reset.
- Inputs are ignored outside IDLE. Changing `a`/`b` during BUSY has no effect.
- Reset mid-operation (any state): return to IDLE immediately, discard the operation, all registers to 0.

## Timing
- Reset values:
  - `in_ready=1`
  - `out_valid=0`
  - `diff=0`
  - `b_out=0`
  - `ovf=0`
  - state IDLE, counter 0
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from inputs to outputs.
- Latency: `out_valid` rises exactly `N/K` clock edges after the accepting edge. For N=32, K=4 this is 8 cycles.
- `out_ready` may be held high in advance. The result is then consumed on the first DONE cycle, and `in_ready` returns on the next cycle.
- Peak throughput: one operation per `N/K + 2` cycles.
- With `out_ready=0`, DONE holds indefinitely and no new operands are accepted.
- K = N is legal: a single BUSY cycle.

## Configuration
- `SUB_SERIAL_OVF_EN` defined:
  - Adds output `ovf`, the two's-complement overflow. It is computed as `(a[N-1] ^ b[N-1]) & (diff[N-1] ^ a[N-1])`, using the latched operands.
  - `ovf` is latched with `b_out`, valid in DONE, and reset to 0.
- Not defined: the `ovf` port and its logic are absent, and all other behaviour is identical.

## Test plan
- a=5, b=3, b_in=0, `out_ready=1` → `out_valid` 8 cycles after accept, diff=0x00000002, b_out=0.
- a=0, b=1, b_in=0 → diff=0xFFFFFFFF, b_out=1. Then a=0, b=0, b_in=1 → diff=0xFFFFFFFF, b_out=1.
- a=0x12345678, b=0x12345678, `out_ready` held 0 for 5 cycles after `out_valid`:
  - diff=0, b_out=0, held stable.
  - `in_ready=0` throughout.
  - `in_ready=1` the cycle after the `out_ready` pulse.
- Reset asserted in the 4th BUSY cycle:
  - Immediately `out_valid=0`, `in_ready=1`, diff=0.
  - A new op a=10, b=7 then yields diff=3 with normal latency.
- Back-to-back ops with `in_valid` held high and 100 random vectors, each checked against `a - b - b_in` → correct results, each accepted exactly once. Repeat with K=1, K=8 and K=32, where K=32 gives 1-cycle latency.
- With `SUB_SERIAL_OVF_EN`:
  - a=0x80000000, b=1 → diff=0x7FFFFFFF, ovf=1.
  - a=5, b=3 → ovf=0.
